// File: rtl/rfm_pkg.sv
// rtl/rfm_pkg.sv - shared FSM encodings and default thresholds for rfm_issue_ctrl
// Defaults here are the fallback parameter values of every block in the slice.
package rfm_pkg;

  localparam int DEF_ADDR_SIZE   = 18;
  localparam int DEF_RAA_IMT     = 8;
  localparam int DEF_RAA_MMT     = 24;
  localparam int DEF_RAA_BITS    = 6;
  localparam int DEF_REF_DEC     = 4;
  localparam int DEF_ACT_GAP     = 4;
  localparam int DEF_NRR_TIMEOUT = 16;
  localparam int DEF_TO_BITS     = 5;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_REQ      = 2'd1;
  localparam logic [1:0] S_ISSUE    = 2'd2;
  localparam logic [1:0] S_WAIT_NRR = 2'd3;

endpackage

// File: rtl/rfm_issue_ctrl_if.sv
// rtl/rfm_issue_ctrl_if.sv - scheduler and tracker signal bundle for rfm_issue_ctrl
// slave is the controller side, master is the scheduler/tracker environment.
interface rfm_issue_ctrl_if
  import rfm_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int RAA_BITS  = DEF_RAA_BITS
);

  logic                 act_in;
  logic [ADDR_SIZE-1:0] act_addr_in;
  logic                 ref_in;
  logic                 rfm_gnt;
  logic                 nrr_cmd;
  logic [ADDR_SIZE-1:0] nrr_addr;
  logic                 act_cmd;
  logic [ADDR_SIZE-1:0] act_addr;
  logic                 rfm_req;
  logic                 rfm_cmd;
  logic                 act_block;
  logic [RAA_BITS-1:0]  raa_cnt;
  logic                 nrr_done;
  logic [ADDR_SIZE-1:0] last_nrr_addr;
  logic                 rfm_err;
  logic                 act_viol;

  modport slave (
    input  act_in, act_addr_in, ref_in, rfm_gnt, nrr_cmd, nrr_addr,
    output act_cmd, act_addr, rfm_req, rfm_cmd, act_block, raa_cnt,
           nrr_done, last_nrr_addr, rfm_err, act_viol
  );

  modport master (
    output act_in, act_addr_in, ref_in, rfm_gnt, nrr_cmd, nrr_addr,
    input  act_cmd, act_addr, rfm_req, rfm_cmd, act_block, raa_cnt,
           nrr_done, last_nrr_addr, rfm_err, act_viol
  );

endinterface

// File: rtl/rfm_raa_counter.sv
// rtl/rfm_raa_counter.sv - saturating RAA counter
// ACT, REF and RFM-completion events can all land in one cycle; the sum is clamped once.
module rfm_raa_counter
  import rfm_pkg::*;
#(
  parameter int RAA_BITS = DEF_RAA_BITS,
  parameter int RAA_IMT  = DEF_RAA_IMT,
  parameter int REF_DEC  = DEF_REF_DEC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_act,
  input  logic                i_ref,
  input  logic                i_dec,
  output logic [RAA_BITS-1:0] o_raa
);

  localparam int W = RAA_BITS + 2;
  localparam logic signed [W-1:0] C_ONE = W'(1);
  localparam logic signed [W-1:0] C_REF = W'(REF_DEC);
  localparam logic signed [W-1:0] C_IMT = W'(RAA_IMT);
  localparam logic signed [W-1:0] C_MAX = W'((1 << RAA_BITS) - 1);

  logic [RAA_BITS-1:0] r_raa;
  logic signed [W-1:0] w_sum;

  always_comb begin
    w_sum = $signed({2'b00, r_raa});
    if (i_act) w_sum = w_sum + C_ONE;
    if (i_ref) w_sum = w_sum - C_REF;
    if (i_dec) w_sum = w_sum - C_IMT;
  end

  always_ff @(posedge clk) begin
    if (rst)                r_raa <= '0;
    else if (w_sum[W-1])    r_raa <= '0;
    else if (w_sum > C_MAX) r_raa <= '1;
    else                    r_raa <= w_sum[RAA_BITS-1:0];
  end

  assign o_raa = r_raa;

endmodule

// File: rtl/rfm_issue_ctrl.sv
// rtl/rfm_issue_ctrl.sv - per-bank RFM initiator between command scheduler and tracker
// Forwards ACTs, tracks RAA, requests/issues RFM and waits for the tracker's NRR response.
module rfm_issue_ctrl
  import rfm_pkg::*;
#(
  parameter int ADDR_SIZE   = DEF_ADDR_SIZE,
  parameter int RAA_IMT     = DEF_RAA_IMT,
  parameter int RAA_MMT     = DEF_RAA_MMT,
  parameter int RAA_BITS    = DEF_RAA_BITS,
  parameter int REF_DEC     = DEF_REF_DEC,
  parameter int ACT_GAP     = DEF_ACT_GAP,
  parameter int NRR_TIMEOUT = DEF_NRR_TIMEOUT,
  parameter int TO_BITS     = DEF_TO_BITS
) (
  input  logic              clk,
  input  logic              rst,
  rfm_issue_ctrl_if.slave   io_rfm
);

  localparam logic [RAA_BITS-1:0] C_IMT     = RAA_BITS'(RAA_IMT);
  localparam logic [RAA_BITS-1:0] C_MMT     = RAA_BITS'(RAA_MMT);
  localparam logic [TO_BITS-1:0]  C_GAP     = TO_BITS'(ACT_GAP);
  localparam logic [TO_BITS-1:0]  C_TO_LAST = TO_BITS'(NRR_TIMEOUT - 1);

  logic [1:0]           r_state;
  logic [TO_BITS-1:0]   r_gap;
  logic [TO_BITS-1:0]   r_to;
  logic                 r_act_cmd;
  logic [ADDR_SIZE-1:0] r_act_addr;
  logic                 r_nrr_done;
  logic [ADDR_SIZE-1:0] r_last_nrr_addr;
  logic                 r_rfm_err;
  logic                 r_act_viol;

  logic [RAA_BITS-1:0]  w_raa;
  logic                 w_act_block;
  logic                 w_rfm_req;
  logic                 w_act_acc;
  logic                 w_gnt_ok;
  logic                 w_nrr_acc;
  logic                 w_timeout;
  logic                 w_close;

  assign w_act_block = (w_raa >= C_MMT) || (r_gap != '0) ||
                       (r_state == S_ISSUE) || (r_state == S_WAIT_NRR);
  assign w_rfm_req   = (r_state == S_REQ) && (r_gap == '0);
  assign w_act_acc   = io_rfm.act_in && !w_act_block;
  // A grant colliding with an ACT loses: the ACT already owns this cycle's slot.
  assign w_gnt_ok    = w_rfm_req && io_rfm.rfm_gnt && !io_rfm.act_in;
  assign w_nrr_acc   = (r_state == S_WAIT_NRR) && io_rfm.nrr_cmd;
  assign w_timeout   = (r_state == S_WAIT_NRR) && !io_rfm.nrr_cmd && (r_to == C_TO_LAST);
  assign w_close     = w_nrr_acc || w_timeout;

  rfm_raa_counter #(
    .RAA_BITS (RAA_BITS),
    .RAA_IMT  (RAA_IMT),
    .REF_DEC  (REF_DEC)
  ) u_raa (
    .clk   (clk),
    .rst   (rst),
    .i_act (w_act_acc),
    .i_ref (io_rfm.ref_in),
    .i_dec (w_close),
    .o_raa (w_raa)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_gap           <= '0;
      r_to            <= '0;
      r_act_cmd       <= 1'b0;
      r_act_addr      <= '0;
      r_nrr_done      <= 1'b0;
      r_last_nrr_addr <= '0;
      r_rfm_err       <= 1'b0;
      r_act_viol      <= 1'b0;
    end else begin
      r_act_cmd  <= w_act_acc;
      r_nrr_done <= w_nrr_acc;
      if (w_act_acc) r_act_addr <= io_rfm.act_addr_in;
      if (io_rfm.act_in && w_act_block) r_act_viol <= 1'b1;

      // The post-RFM gap also masks the tracker's slow release of its nrr_cmd level.
      if (w_act_acc || w_close) r_gap <= C_GAP;
      else if (r_gap != '0)     r_gap <= r_gap - 1'b1;

      case (r_state)
        S_IDLE:  if (w_raa >= C_IMT) r_state <= S_REQ;
        S_REQ:   if (w_gnt_ok) r_state <= S_ISSUE;
        S_ISSUE: begin
          r_state <= S_WAIT_NRR;
          r_to    <= '0;
        end
        S_WAIT_NRR: begin
          if (w_nrr_acc) begin
            r_last_nrr_addr <= io_rfm.nrr_addr;
            r_state         <= S_IDLE;
          end else if (w_timeout) begin
            r_rfm_err <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_rfm.act_cmd       = r_act_cmd;
  assign io_rfm.act_addr      = r_act_addr;
  assign io_rfm.rfm_req       = w_rfm_req;
  assign io_rfm.rfm_cmd       = (r_state == S_ISSUE);
  assign io_rfm.act_block     = w_act_block;
  assign io_rfm.raa_cnt       = w_raa;
  assign io_rfm.nrr_done      = r_nrr_done;
  assign io_rfm.last_nrr_addr = r_last_nrr_addr;
  assign io_rfm.rfm_err       = r_rfm_err;
  assign io_rfm.act_viol      = r_act_viol;

endmodule

// File: tb/tb_rfm_issue_ctrl.sv
// tb/tb_rfm_issue_ctrl.sv - self-checking bench for rfm_issue_ctrl
// Table vectors, directed corner sequences and random traffic against a cycle model.
module tb_rfm_issue_ctrl;

  localparam int AW   = 18;
  localparam int RB   = 6;
  localparam int IMT  = 8;
  localparam int MMT  = 24;
  localparam int RD   = 4;
  localparam int GAP  = 4;
  localparam int TMO  = 16;
  localparam int RMAX = (1 << RB) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rfm_issue_ctrl_if #(.ADDR_SIZE(AW), .RAA_BITS(RB)) bus ();

  rfm_issue_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .io_rfm (bus)
  );

  int    total = 0;
  int    bad   = 0;
  string sect  = "init";

  typedef enum {M_IDLE, M_REQ, M_ISSUE, M_WAIT} mph_t;
  mph_t    m_ph;
  int      m_raa, m_gap, m_wait;
  bit      m_cmd, m_done, m_err, m_viol;
  logic [AW-1:0] m_addr, m_last;

  bit d_ai, d_rf, d_gnt, d_nrr;
  logic [AW-1:0] d_addr, d_naddr;

  typedef struct {
    bit ai; bit rf; bit gnt; bit nrr;
    int raa; bit cmd; bit blk; bit req; bit viol; bit done;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s/%s: got %0h want %0h", sect, nm, act, exp);
    end
  endtask

  task automatic drive(bit ai, logic [AW-1:0] a, bit rf, bit g, bit n, logic [AW-1:0] na);
    d_ai = ai; d_addr = a; d_rf = rf; d_gnt = g; d_nrr = n; d_naddr = na;
    bus.act_in = ai; bus.act_addr_in = a; bus.ref_in = rf;
    bus.rfm_gnt = g; bus.nrr_cmd = n; bus.nrr_addr = na;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  function automatic bit m_blocked();
    return (m_raa >= MMT) || (m_gap != 0) || (m_ph == M_ISSUE) || (m_ph == M_WAIT);
  endfunction

  task automatic model_reset();
    m_ph = M_IDLE; m_raa = 0; m_gap = 0; m_wait = 0;
    m_cmd = 0; m_done = 0; m_err = 0; m_viol = 0; m_addr = '0; m_last = '0;
  endtask

  task automatic model_step();
    bit blk    = m_blocked();
    bit acc    = d_ai && !blk;
    bit grant  = (m_ph == M_REQ) && (m_gap == 0) && d_gnt && !d_ai;
    bit fin_ok = (m_ph == M_WAIT) && d_nrr;
    bit fin_to = (m_ph == M_WAIT) && !d_nrr && (m_wait == TMO - 1);
    int old_raa = m_raa;
    int r = m_raa + (acc ? 1 : 0) - (d_rf ? RD : 0) - ((fin_ok || fin_to) ? IMT : 0);
    m_raa = (r < 0) ? 0 : ((r > RMAX) ? RMAX : r);
    m_cmd = acc;
    if (acc) m_addr = d_addr;
    if (d_ai && blk) m_viol = 1;
    m_done = fin_ok;
    if (fin_ok) m_last = d_naddr;
    if (fin_to) m_err = 1;
    if (acc || fin_ok || fin_to) m_gap = GAP;
    else if (m_gap > 0) m_gap--;
    case (m_ph)
      M_IDLE:  if (old_raa >= IMT) m_ph = M_REQ;
      M_REQ:   if (grant) m_ph = M_ISSUE;
      M_ISSUE: begin m_ph = M_WAIT; m_wait = 0; end
      M_WAIT:  if (fin_ok || fin_to) m_ph = M_IDLE; else m_wait++;
      default: m_ph = M_IDLE;
    endcase
  endtask

  task automatic compare_all();
    chk("act_cmd", bus.act_cmd, m_cmd);
    chk("act_addr", bus.act_addr, m_addr);
    chk("rfm_req", bus.rfm_req, (m_ph == M_REQ) && (m_gap == 0));
    chk("rfm_cmd", bus.rfm_cmd, m_ph == M_ISSUE);
    chk("act_block", bus.act_block, m_blocked());
    chk("raa_cnt", bus.raa_cnt, m_raa);
    chk("nrr_done", bus.nrr_done, m_done);
    chk("last_nrr_addr", bus.last_nrr_addr, m_last);
    chk("rfm_err", bus.rfm_err, m_err);
    chk("act_viol", bus.act_viol, m_viol);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    model_reset();
    compare_all();
    rst = 1'b0;
  endtask

  // n ACTs to row 0x123, each followed by enough idle cycles for the gap to expire
  task automatic acts(int n, int base);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, 18'h00123, 1'b0, 1'b0, 1'b0, '0);
      step();
      chk("act_fwd", bus.act_cmd, 1);
      chk("act_row", bus.act_addr, 18'h00123);
      chk("raa_step", bus.raa_cnt, base + k + 1);
      idle();
      repeat (GAP) step();
    end
  endtask

  initial begin
    idle();
    tbl[0]  = '{1,0,0,0, 1,1,1,0,0,0};
    tbl[1]  = '{0,1,0,0, 0,0,1,0,0,0};
    tbl[2]  = '{0,0,0,0, 0,0,1,0,0,0};
    tbl[3]  = '{0,0,0,0, 0,0,1,0,0,0};
    tbl[4]  = '{0,0,0,0, 0,0,0,0,0,0};
    tbl[5]  = '{1,1,0,0, 0,1,1,0,0,0};
    tbl[6]  = '{1,0,0,0, 0,0,1,0,1,0};
    tbl[7]  = '{0,1,0,0, 0,0,1,0,1,0};
    tbl[8]  = '{0,0,0,0, 0,0,1,0,1,0};
    tbl[9]  = '{0,0,0,0, 0,0,0,0,1,0};
    tbl[10] = '{0,0,0,1, 0,0,0,0,1,0};
    tbl[11] = '{0,0,1,0, 0,0,0,0,1,0};

    sect = "table";
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].ai, 18'h00123, tbl[i].rf, tbl[i].gnt, tbl[i].nrr, 18'h00321);
      step();
      chk("v_raa", bus.raa_cnt, tbl[i].raa);
      chk("v_cmd", bus.act_cmd, tbl[i].cmd);
      chk("v_blk", bus.act_block, tbl[i].blk);
      chk("v_req", bus.rfm_req, tbl[i].req);
      chk("v_viol", bus.act_viol, tbl[i].viol);
      chk("v_done", bus.nrr_done, tbl[i].done);
    end

    sect = "t1_acts";
    do_reset();
    acts(7, 0);
    drive(1'b1, 18'h00123, 1'b0, 1'b0, 1'b0, '0);
    step();
    chk("raa8", bus.raa_cnt, 8);
    idle();
    repeat (GAP - 1) step();
    chk("req_gap", bus.rfm_req, 0);
    step();
    chk("req_up", bus.rfm_req, 1);

    sect = "t2_rfm";
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    step();
    chk("rfm_cmd", bus.rfm_cmd, 1);
    chk("blk_issue", bus.act_block, 1);
    idle();
    step();
    chk("rfm_cmd_off", bus.rfm_cmd, 0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 18'h00123);
    step();
    chk("done", bus.nrr_done, 1);
    chk("last", bus.last_nrr_addr, 18'h00123);
    chk("raa0", bus.raa_cnt, 0);
    step();
    chk("done_once", bus.nrr_done, 0);
    idle();
    for (int i = 0; i < GAP - 2; i++) begin
      step();
      chk("blk_gap", bus.act_block, 1);
    end
    step();
    chk("blk_free", bus.act_block, 0);

    sect = "t3_mmt";
    do_reset();
    acts(24, 0);
    chk("blk_mmt", bus.act_block, 1);
    drive(1'b1, 18'h00777, 1'b0, 1'b0, 1'b0, '0);
    step();
    chk("drop", bus.act_cmd, 0);
    chk("viol", bus.act_viol, 1);
    chk("raa24", bus.raa_cnt, 24);

    sect = "t4_ref";
    do_reset();
    acts(2, 0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    step();
    chk("floor", bus.raa_cnt, 0);
    idle();
    step();
    acts(6, 0);
    drive(1'b1, 18'h00123, 1'b1, 1'b0, 1'b0, '0);
    step();
    chk("act_ref", bus.raa_cnt, 3);

    sect = "t5_tmo";
    do_reset();
    acts(8, 0);
    chk("req", bus.rfm_req, 1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    step();
    idle();
    step();
    repeat (TMO - 1) step();
    chk("no_err_yet", bus.rfm_err, 0);
    chk("raa_held", bus.raa_cnt, 8);
    step();
    chk("err", bus.rfm_err, 1);
    chk("raa_dec", bus.raa_cnt, 0);
    chk("idle_req", bus.rfm_req, 0);

    sect = "t6_rst";
    do_reset();
    acts(8, 0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    step();
    idle();
    step();
    step();
    do_reset();
    chk("rst_cmd", bus.rfm_cmd, 0);
    chk("rst_raa", bus.raa_cnt, 0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 18'h003ff);
    step();
    chk("ign_done", bus.nrr_done, 0);
    chk("ign_last", bus.last_nrr_addr, 0);
    idle();
    repeat (5) step();

    sect = "random";
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 3) == 0, AW'($urandom), ($urandom % 8) == 0,
            ($urandom % 2) == 0, ($urandom % 4) == 0, AW'($urandom));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rfm_issue_ctrl.md
Name: rfm_issue_ctrl

Overview:
Per-bank, controller-side initiator of the RFM protocol.
- Forwards scheduler ACTs to the bank's RFM tracking unit (act_cmd/act_addr).
- Keeps a rolling accumulated ACT (RAA) count and issues rfm_cmd through a req/gnt handshake with the command scheduler.
- Consumes the tracker's nrr_cmd/nrr_addr response and blocks ACTs while the tracker is busy or RAA is at its maximum.
- Sits between the per-bank command scheduler and the per-bank RFM tracking unit.

Parameters:
ADDR_SIZE, 18, row address width
RAA_IMT, 8, RAA initial management threshold; issue RFM at or above this
RAA_MMT, 24, RAA maximum threshold; block ACT at or above this
RAA_BITS, 6, RAA counter width; saturates at 2^RAA_BITS-1
REF_DEC, 4, RAA decrement per REF
ACT_GAP, 4, cycles act_block stays high after a forwarded ACT or an RFM completion
NRR_TIMEOUT, 16, WAIT_NRR cycles before declaring an error
TO_BITS, 5, timeout/gap counter width; must satisfy 2^TO_BITS > max(NRR_TIMEOUT, ACT_GAP)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
act_in  in  1  ACT issued by scheduler
act_addr_in  in  ADDR_SIZE  ACT row address
ref_in  in  1  REF issued to this bank
rfm_gnt  in  1  scheduler grants RFM slot
nrr_cmd  in  1  tracker's neighbour-row-refresh response (level)
nrr_addr  in  ADDR_SIZE  aggressor row from tracker
act_cmd  out  1  forwarded ACT to tracker
act_addr  out  ADDR_SIZE  forwarded ACT address
rfm_req  out  1  RFM request to scheduler
rfm_cmd  out  1  RFM pulse to tracker
act_block  out  1  scheduler must not issue ACT
raa_cnt  out  RAA_BITS  current RAA value
nrr_done  out  1  one-cycle pulse: RFM completed
last_nrr_addr  out  ADDR_SIZE  aggressor row from the last completed RFM
rfm_err  out  1  sticky: NRR timeout occurred
act_viol  out  1  sticky: ACT received while act_block was high

Behaviour:
Reset and registers
- Reset is synchronous, active-high.
- All outputs reset to 0; FSM resets to IDLE; gap and timeout counters reset to 0.
- All outputs are registered.

ACT path
- Accepted ACT = act_in && !act_block.
- An accepted ACT drives act_cmd=1 and act_addr=act_addr_in on the next cycle, loads gap=ACT_GAP and counts +1 in RAA.
- act_addr holds its value otherwise.
- act_in while act_block is high: the ACT is dropped (not forwarded, not counted) and act_viol is set; act_viol is sticky until rst.

RAA arithmetic
- raa_next = clamp(raa + accepted_act − ref_in·REF_DEC − nrr_accept·RAA_IMT, 0, 2^RAA_BITS−1).
- Computed at width RAA_BITS+2 signed, so all simultaneous events apply in one cycle.
- Example: at raa=6, act and ref together give raa=3.

act_block
- act_block = (raa ≥ RAA_MMT) || gap≠0 || state∈{ISSUE, WAIT_NRR}, evaluated on registered values.
- gap decrements by 1 per cycle while nonzero.

FSM (IDLE, REQ, ISSUE, WAIT_NRR)
- IDLE: when raa ≥ RAA_IMT, go to REQ.
- REQ:
  - rfm_req = (gap==0).
  - rfm_gnt is honoured only while rfm_req=1.
  - If rfm_gnt and act_in occur in the same cycle, the grant is ignored; stay in REQ.
  - On an honoured grant, go to ISSUE.
- ISSUE: rfm_cmd=1 for exactly one cycle; go to WAIT_NRR and clear the timeout counter.
- WAIT_NRR:
  - The first cycle with nrr_cmd=1 is the accept (nrr_accept):
    - capture last_nrr_addr=nrr_addr;
    - pulse nrr_done;
    - RAA −= RAA_IMT;
    - load gap=ACT_GAP;
    - go to IDLE.
  - The gap covers the tracker dropping nrr_cmd level.
  - After NRR_TIMEOUT cycles without nrr_cmd:
    - set rfm_err (sticky);
    - apply the RAA −= RAA_IMT decrement anyway;
    - load gap;
    - go to IDLE.
- ref_in is legal in any state.
- nrr_cmd outside WAIT_NRR is ignored.
- rst mid-RFM returns to IDLE with no re-issue of rfm_cmd.

Latency
- ACT forwarding: 1 cycle.
- raa ≥ RAA_IMT to rfm_req: 1 cycle (2 cycles from the triggering ACT), subject to gap.

Decomposition:
- Shared package rfm_pkg: FSM state encodings and default threshold constants (RAA_IMT, RAA_MMT, REF_DEC, ACT_GAP, NRR_TIMEOUT).
- One sub-module: rfm_raa_counter, the saturating up/down counter with clamped multi-event update.

Test Plan:
1. Reset, then 8 ACTs to 0x00123 spaced 5 cycles → act_cmd follows each by 1 cycle, raa_cnt steps 1..8, rfm_req=1 once gap=0.
2. From test 1, pulse rfm_gnt → rfm_cmd single pulse next cycle; act_block=1; nrr_cmd with nrr_addr=0x00123 three cycles later → nrr_done pulse, last_nrr_addr=0x00123, raa_cnt=0, act_block stays high 4 more cycles.
3. 24 ACTs with no grant → act_block held at raa=24; a 25th act_in is not forwarded, act_viol=1, raa_cnt stays 24.
4. raa=2 plus ref_in → raa 0 (floor). raa=6 with act_in and ref_in in the same cycle → raa 3.
5. Grant issued, nrr_cmd never asserted → after 16 WAIT_NRR cycles rfm_err=1, raa reduced by 8, FSM back to IDLE.
6. rst asserted during WAIT_NRR → all outputs 0 at the next edge, no rfm_cmd; a later nrr_cmd is ignored.
